// File: rtl/mac_seq_ctrl_if.sv
// Handshake and datapath bundle between the tile scheduler/operand FIFOs,
// the MAC sequencer and one mac_unit instance.
interface mac_seq_ctrl_if #(
  parameter int DATA_WIDTH = 16,
  parameter int ACC_WIDTH  = 32,
  parameter int K_WIDTH    = 9
);
  logic                  start;
  logic [K_WIDTH-1:0]    cfg_k;
  logic                  abort;
  logic                  busy;
  logic                  op_valid;
  logic                  op_ready;
  logic [DATA_WIDTH-1:0] op_a;
  logic [DATA_WIDTH-1:0] op_b;
  logic                  mac_en;
  logic                  mac_clear;
  logic [DATA_WIDTH-1:0] mac_a;
  logic [DATA_WIDTH-1:0] mac_b;
  logic [ACC_WIDTH-1:0]  mac_acc;
  logic                  res_valid;
  logic                  res_ready;
  logic [ACC_WIDTH-1:0]  res_data;
  logic                  res_nan;

  modport master (
    output start, cfg_k, abort, op_valid, op_a, op_b, mac_acc, res_ready,
    input  busy, op_ready, mac_en, mac_clear, mac_a, mac_b, res_valid, res_data, res_nan
  );

  modport slave (
    input  start, cfg_k, abort, op_valid, op_a, op_b, mac_acc, res_ready,
    output busy, op_ready, mac_en, mac_clear, mac_a, mac_b, res_valid, res_data, res_nan
  );
endinterface

// File: rtl/mac_seq_ctrl.sv
// Sequences one mac_unit through a K-term BF16 dot product: clear, K enabled
// operand beats, one zero-operand drain beat, then a held FP32 result.
module mac_seq_ctrl #(
  parameter int DATA_WIDTH = 16,
  parameter int ACC_WIDTH  = 32,
  parameter int K_WIDTH    = 9
) (
  input logic          clk,
  input logic          rst_n,
  mac_seq_ctrl_if.slave bus
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_FEED,
    S_DRAIN,
    S_DONE
  } state_t;

  localparam logic [ACC_WIDTH-1:0] QNAN = ACC_WIDTH'(32'h7FC0_0000);

  state_t                r_state;
  state_t                w_next;
  logic [K_WIDTH-1:0]    r_remain;

  logic                  w_abort;
  logic                  w_accept;
  logic                  w_busy;
  logic                  w_op_ready;
  logic                  w_mac_en;
  logic                  w_mac_clear;
  logic                  w_res_valid;
  logic [DATA_WIDTH-1:0] w_mac_a;
  logic [DATA_WIDTH-1:0] w_mac_b;
  logic [ACC_WIDTH-1:0]  w_res_data;

  assign w_abort = bus.abort && (r_state != S_IDLE);

  always_comb begin
    w_next      = r_state;
    w_busy      = (r_state != S_IDLE);
    w_op_ready  = 1'b0;
    w_accept    = 1'b0;
    w_mac_en    = 1'b0;
    w_mac_clear = 1'b0;
    w_mac_a     = '0;
    w_mac_b     = '0;
    w_res_valid = 1'b0;
    w_res_data  = '0;

    case (r_state)
      S_IDLE: begin
        if (bus.start) w_next = S_CLEAR;
      end
      S_CLEAR: begin
        w_mac_clear = 1'b1;
        w_next      = (r_remain != '0) ? S_FEED : S_DRAIN;
      end
      S_FEED: begin
        w_op_ready = 1'b1;
        w_accept   = bus.op_valid;
        if (w_accept) begin
          w_mac_en = 1'b1;
          w_mac_a  = bus.op_a;
          w_mac_b  = bus.op_b;
          if (r_remain == K_WIDTH'(1)) w_next = S_DRAIN;
        end
      end
      S_DRAIN: begin
        // Zero operands: pushes the last product into the accumulator, adds 0.
        w_mac_en = 1'b1;
        w_next   = S_DONE;
      end
      S_DONE: begin
        w_res_valid = 1'b1;
        w_res_data  = bus.mac_acc;
        if (bus.res_ready) w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase

    // Abort overrides every handshake so no pair or result changes hands.
    if (w_abort) begin
      w_next      = S_IDLE;
      w_mac_clear = 1'b1;
      w_mac_en    = 1'b0;
      w_op_ready  = 1'b0;
      w_accept    = 1'b0;
      w_mac_a     = '0;
      w_mac_b     = '0;
      w_res_valid = 1'b0;
      w_res_data  = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= S_IDLE;
      r_remain <= '0;
    end else begin
      r_state <= w_next;
      if (w_abort)
        r_remain <= '0;
      else if ((r_state == S_IDLE) && bus.start)
        r_remain <= bus.cfg_k;
      else if (w_accept)
        r_remain <= r_remain - K_WIDTH'(1);
    end
  end

  assign bus.busy      = w_busy;
  assign bus.op_ready  = w_op_ready;
  assign bus.mac_en    = w_mac_en;
  assign bus.mac_clear = w_mac_clear;
  assign bus.mac_a     = w_mac_a;
  assign bus.mac_b     = w_mac_b;
  assign bus.res_valid = w_res_valid;
  assign bus.res_data  = w_res_data;
  assign bus.res_nan   = w_res_valid && (w_res_data == QNAN);

endmodule

// File: tb/tb_mac_seq_ctrl.sv
// Directed bench for mac_seq_ctrl with a behavioural 2-stage BF16 MAC model
// supplying the accumulator.
module tb_mac_seq_ctrl;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  mac_seq_ctrl_if #(.DATA_WIDTH(16), .ACC_WIDTH(32), .K_WIDTH(9)) bus ();

  mac_seq_ctrl #(.DATA_WIDTH(16), .ACC_WIDTH(32), .K_WIDTH(9)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  function automatic real bf2r(input logic [15:0] x);
    real v;
    int  e;
    if (x[14:7] == 8'd0) return 0.0;
    v = 1.0 + real'(x[6:0]) / 128.0;
    e = int'(x[14:7]) - 127;
    while (e > 0) begin v = v * 2.0; e--; end
    while (e < 0) begin v = v / 2.0; e++; end
    return x[15] ? -v : v;
  endfunction

  function automatic logic [31:0] r2f(input real r);
    logic [63:0] d;
    int          e32;
    if (r == 0.0) return 32'h0;
    d   = $realtobits(r);
    e32 = int'(d[62:52]) - 896;
    return {d[63], e32[7:0], d[51:29]};
  endfunction

  // mac_unit model: en moves the product register and the accumulator together
  real s1_r, acc_r;
  bit  s1_nan, acc_nan;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_r <= 0.0; acc_r <= 0.0; s1_nan <= 1'b0; acc_nan <= 1'b0;
    end else if (bus.mac_clear) begin
      s1_r <= 0.0; acc_r <= 0.0; s1_nan <= 1'b0; acc_nan <= 1'b0;
    end else if (bus.mac_en) begin
      acc_r   <= acc_r + s1_r;
      acc_nan <= acc_nan | s1_nan;
      s1_r    <= bf2r(bus.mac_a) * bf2r(bus.mac_b);
      s1_nan  <= (bus.mac_a[14:7] == 8'hFF) || (bus.mac_b[14:7] == 8'hFF);
    end
  end
  always @* bus.mac_acc = acc_nan ? 32'h7FC0_0000 : r2f(acc_r);

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_busy"},      32'(bus.busy),      32'h0);
    chk({tag, "_op_ready"},  32'(bus.op_ready),  32'h0);
    chk({tag, "_mac_en"},    32'(bus.mac_en),    32'h0);
    chk({tag, "_mac_clear"}, 32'(bus.mac_clear), 32'h0);
    chk({tag, "_mac_a"},     32'(bus.mac_a),     32'h0);
    chk({tag, "_mac_b"},     32'(bus.mac_b),     32'h0);
    chk({tag, "_res_valid"}, 32'(bus.res_valid), 32'h0);
    chk({tag, "_res_data"},  bus.res_data,       32'h0);
    chk({tag, "_res_nan"},   32'(bus.res_nan),   32'h0);
  endtask

  typedef struct packed {
    int               k;
    logic [3:0][15:0] a;
    logic [3:0][15:0] b;
    int               gap;
    int               hold;
    logic [31:0]      exp_data;
    logic             exp_nan;
    int               exp_lat;
  } job_vec_t;

  // Runs one job from IDLE; latency is counted from the start cycle.
  task automatic run_job(input string tag, input int k, input logic [3:0][15:0] a,
                         input logic [3:0][15:0] b, input int gap, input int hold,
                         input logic [31:0] exp_data, input logic exp_nan, input int exp_lat);
    int          cyc = 0, idx = 0, g = gap, h = 0, lat = -1, ens = 0, clrs = 0;
    bit          done = 0, stable = 1;
    logic [31:0] data = '0;
    logic        nan = 1'b0;
    @(negedge clk);
    bus.start = 1'b1; bus.cfg_k = k[8:0]; bus.op_valid = 1'b0; bus.res_ready = 1'b0;
    @(negedge clk);
    bus.start = 1'b0;
    cyc = 1;
    while (!done && cyc < 200) begin
      bus.op_valid  = (idx < k) && (g >= gap);
      bus.op_a      = (idx < k) ? a[idx] : 16'h0;
      bus.op_b      = (idx < k) ? b[idx] : 16'h0;
      bus.res_ready = (h >= hold);
      #1;
      if (bus.mac_en) ens++;
      if (bus.mac_clear) clrs++;
      if (bus.op_valid && bus.op_ready) begin idx++; g = 0; end
      else if (bus.op_ready) g++;
      if (bus.res_valid) begin
        if (lat < 0) begin lat = cyc; data = bus.res_data; nan = bus.res_nan; end
        else if (bus.res_data !== data) stable = 0;
        if (bus.res_ready) done = 1; else h++;
      end
      @(negedge clk);
      cyc++;
    end
    bus.op_valid = 1'b0; bus.res_ready = 1'b0; bus.op_a = '0; bus.op_b = '0;
    #1;
    chk({tag, "_done"},     32'(done),         32'h1);
    chk({tag, "_res_data"}, data,              exp_data);
    chk({tag, "_res_nan"},  32'(nan),          32'(exp_nan));
    chk({tag, "_en_count"}, 32'(ens),          32'(k + 1));
    chk({tag, "_clr_count"},32'(clrs),         32'h1);
    chk({tag, "_stable"},   32'(stable),       32'h1);
    if (exp_lat >= 0) chk({tag, "_latency"}, 32'(lat), 32'(exp_lat));
    chk({tag, "_idle_busy"},  32'(bus.busy),      32'h0);
    chk({tag, "_idle_valid"}, 32'(bus.res_valid), 32'h0);
  endtask

  job_vec_t vecs[6];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1);
  end

  initial begin
    int seen;
    vecs[0] = '{k: 3, a: {16'h0000, 16'h4040, 16'h4000, 16'h3F80},
                b: {16'h0000, 16'h3F80, 16'h4000, 16'h4000},
                gap: 0, hold: 0, exp_data: 32'h4110_0000, exp_nan: 1'b0, exp_lat: 6};
    vecs[1] = '{k: 3, a: {16'h0000, 16'h4040, 16'h4000, 16'h3F80},
                b: {16'h0000, 16'h3F80, 16'h4000, 16'h4000},
                gap: 2, hold: 3, exp_data: 32'h4110_0000, exp_nan: 1'b0, exp_lat: -1};
    vecs[2] = '{k: 0, a: '0, b: '0,
                gap: 0, hold: 0, exp_data: 32'h0000_0000, exp_nan: 1'b0, exp_lat: 3};
    vecs[3] = '{k: 2, a: {16'h0000, 16'h0000, 16'h3F80, 16'h7FC1},
                b: {16'h0000, 16'h0000, 16'h3F80, 16'h3F80},
                gap: 0, hold: 0, exp_data: 32'h7FC0_0000, exp_nan: 1'b1, exp_lat: 5};
    vecs[4] = '{k: 1, a: {16'h0000, 16'h0000, 16'h0000, 16'h3F80},
                b: {16'h0000, 16'h0000, 16'h0000, 16'h3F80},
                gap: 0, hold: 0, exp_data: 32'h3F80_0000, exp_nan: 1'b0, exp_lat: 4};
    vecs[5] = '{k: 4, a: {16'h3F80, 16'h3F80, 16'h3F80, 16'h3F80},
                b: {16'h3F80, 16'h3F80, 16'h3F80, 16'h3F80},
                gap: 0, hold: 0, exp_data: 32'h4080_0000, exp_nan: 1'b0, exp_lat: 7};

    bus.start = 1'b0; bus.cfg_k = '0; bus.abort = 1'b0; bus.op_valid = 1'b0;
    bus.op_a = '0; bus.op_b = '0; bus.res_ready = 1'b0;
    #12;
    chk_all_zero("reset");
    @(negedge clk);
    rst_n = 1'b1;

    for (int unsigned i = 0; i < 6; i++)
      run_job($sformatf("vec%0d", i), vecs[i].k, vecs[i].a, vecs[i].b, vecs[i].gap,
              vecs[i].hold, vecs[i].exp_data, vecs[i].exp_nan, vecs[i].exp_lat);

    // Reset in the middle of a K=5 job with a pair still on offer
    @(negedge clk); bus.start = 1'b1; bus.cfg_k = 9'd5;
    @(negedge clk); bus.start = 1'b0;
    @(negedge clk); bus.op_valid = 1'b1; bus.op_a = 16'h4000; bus.op_b = 16'h4000;
    @(negedge clk);
    @(negedge clk);
    #1 chk("midfeed_en_before_reset", 32'(bus.mac_en), 32'h1);
    #1 rst_n = 1'b0;
    #1 chk_all_zero("midfeed_reset");
    @(negedge clk); rst_n = 1'b1; bus.op_valid = 1'b0; bus.op_a = '0; bus.op_b = '0;
    run_job("after_reset", 1, {48'h0, 16'h3F80}, {48'h0, 16'h3F80}, 0, 0,
            32'h3F80_0000, 1'b0, 4);

    // Abort a K=4 job after two beats while a third pair is offered
    @(negedge clk); bus.start = 1'b1; bus.cfg_k = 9'd4;
    @(negedge clk); bus.start = 1'b0;
    @(negedge clk); bus.op_valid = 1'b1; bus.op_a = 16'h4000; bus.op_b = 16'h4000;
    @(negedge clk);
    @(negedge clk); bus.abort = 1'b1;
    #1;
    chk("abort_mac_clear", 32'(bus.mac_clear), 32'h1);
    chk("abort_mac_en",    32'(bus.mac_en),    32'h0);
    chk("abort_op_ready",  32'(bus.op_ready),  32'h0);
    @(negedge clk); bus.abort = 1'b0; bus.op_valid = 1'b0; bus.op_a = '0; bus.op_b = '0;
    #1 chk("abort_idle_busy", 32'(bus.busy), 32'h0);
    seen = 0;
    for (int n = 0; n < 8; n++) begin
      @(negedge clk); #1;
      if (bus.res_valid || bus.busy) seen++;
    end
    chk("abort_no_result", 32'(seen), 32'h0);
    run_job("after_abort", 1, {48'h0, 16'h4000}, {48'h0, 16'h4000}, 0, 0,
            32'h4080_0000, 1'b0, 4);

    // Abort is ignored in IDLE: start is still taken
    @(negedge clk); bus.start = 1'b1; bus.abort = 1'b1; bus.cfg_k = 9'd2;
    @(negedge clk); bus.start = 1'b0;
    #1;
    chk("idle_abort_busy",  32'(bus.busy),      32'h1);
    chk("idle_abort_clear", 32'(bus.mac_clear), 32'h1);
    @(negedge clk); bus.abort = 1'b0;
    #1 chk("idle_abort_back_idle", 32'(bus.busy), 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
